// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: oversampled start detection, 5..9 data bits,
// optional odd/even parity, one or two stop bits, and a one-entry
// valid/ready holding register with per-frame error flags and sticky overrun.
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 21812,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 i_reset,
    input  logic                 i_rx,
    input  logic                 i_ready,
    input  logic                 i_clear_overrun,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_overrun,
    output logic                 o_busy
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CW       = $clog2(CLKS_PER_BIT + 1);
    localparam int IW       = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] CNT_LAST      = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF      = CW'(HALF_BIT);
    localparam logic [IW-1:0] IDX_DATA_LAST = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] IDX_STOP_LAST = IW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t                 state;
    logic [CW-1:0]          count;
    logic [IW-1:0]          bit_idx;
    logic [DATA_BITS-1:0]   shift_reg;
    logic                   parity_err_acc;
    logic                   frame_err_acc;
    logic                   s1;
    logic                   s2;

    logic                   sample_tick;
    logic                   frame_done;
    logic                   frame_err_final;
    logic                   parity_calc;
    logic                   parity_bad;

    assign sample_tick     = (count == CNT_LAST);
    assign frame_done      = (state == ST_STOP) && sample_tick && (bit_idx == IDX_STOP_LAST);
    assign frame_err_final = frame_err_acc | ~s2;
    assign parity_calc     = (^shift_reg) ^ s2;
    assign parity_bad      = (PARITY == 1) ? ~parity_calc : parity_calc;

    // Two-flop synchroniser for the asynchronous line; idles high.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else begin
            s1 <= i_rx;
            s2 <= s1;
        end
    end

    // Receive FSM plus the holding register and overrun flag it feeds.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            state          <= ST_IDLE;
            count          <= '0;
            bit_idx        <= '0;
            shift_reg      <= '0;
            parity_err_acc <= 1'b0;
            frame_err_acc  <= 1'b0;
            o_data         <= '0;
            o_valid        <= 1'b0;
            o_parity_err   <= 1'b0;
            o_frame_err    <= 1'b0;
            o_overrun      <= 1'b0;
            o_busy         <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!s2) begin
                        state          <= ST_START;
                        count          <= CW'(1);
                        parity_err_acc <= 1'b0;
                        frame_err_acc  <= 1'b0;
                        o_busy         <= 1'b1;
                    end
                end
                ST_START: begin
                    if (s2) begin
                        state  <= ST_IDLE;
                        count  <= '0;
                        o_busy <= 1'b0;
                    end else if (count == CNT_HALF) begin
                        state   <= ST_DATA;
                        count   <= '0;
                        bit_idx <= '0;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (sample_tick) begin
                        count     <= '0;
                        shift_reg <= {s2, shift_reg[DATA_BITS-1:1]};
                        if (bit_idx == IDX_DATA_LAST) begin
                            bit_idx <= '0;
                            state   <= (PARITY != 0) ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (sample_tick) begin
                        count          <= '0;
                        parity_err_acc <= parity_bad;
                        bit_idx        <= '0;
                        state          <= ST_STOP;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (sample_tick) begin
                        count <= '0;
                        if (!s2) begin
                            frame_err_acc <= 1'b1;
                        end
                        if (bit_idx == IDX_STOP_LAST) begin
                            state     <= ST_IDLE;
                            bit_idx   <= '0;
                            shift_reg <= '0;
                            o_busy    <= 1'b0;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    count  <= '0;
                    o_busy <= 1'b0;
                end
            endcase

            if (frame_done) begin
                if (!o_valid || i_ready) begin
                    o_data       <= shift_reg;
                    o_parity_err <= parity_err_acc;
                    o_frame_err  <= frame_err_final;
                    o_valid      <= 1'b1;
                end
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end

            if (frame_done && o_valid && !i_ready) begin
                o_overrun <= 1'b1;
            end else if (i_clear_overrun) begin
                o_overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: four instances cover 8N1, 8E1, 8N2 and
// 5N1 framing at 16 clocks per bit. Stimulus pushes expected frames; a
// negedge monitor pops and compares each frame the consumer accepts.
module tb_uart_rx_param;

    localparam int CPB = 16;

    typedef struct {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic [3:0] rst;
    logic [3:0] rx;
    logic [3:0] rdy;
    logic [3:0] clr;
    int         cyc = 0;

    logic [7:0] data0, data1, data2;
    logic [4:0] data3;
    logic valid0, perr0, ferr0, ovr0, busy0;
    logic valid1, perr1, ferr1, ovr1, busy1;
    logic valid2, perr2, ferr2, ovr2, busy2;
    logic valid3, perr3, ferr3, ovr3, busy3;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    exp_t q3[$];

    int num_vectors = 0;
    int num_miscompares = 0;

    logic busy0_q = 1'b0;
    int   busy0_rise = -1;
    int   busy0_fall = -1;

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_8n1 (
        .clk(clk), .i_reset(rst[0]), .i_rx(rx[0]), .i_ready(rdy[0]), .i_clear_overrun(clr[0]),
        .o_data(data0), .o_valid(valid0), .o_parity_err(perr0), .o_frame_err(ferr0),
        .o_overrun(ovr0), .o_busy(busy0));

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_8e1 (
        .clk(clk), .i_reset(rst[1]), .i_rx(rx[1]), .i_ready(rdy[1]), .i_clear_overrun(clr[1]),
        .o_data(data1), .o_valid(valid1), .o_parity_err(perr1), .o_frame_err(ferr1),
        .o_overrun(ovr1), .o_busy(busy1));

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) dut_8n2 (
        .clk(clk), .i_reset(rst[2]), .i_rx(rx[2]), .i_ready(rdy[2]), .i_clear_overrun(clr[2]),
        .o_data(data2), .o_valid(valid2), .o_parity_err(perr2), .o_frame_err(ferr2),
        .o_overrun(ovr2), .o_busy(busy2));

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(5), .PARITY(0), .STOP_BITS(1)) dut_5n1 (
        .clk(clk), .i_reset(rst[3]), .i_rx(rx[3]), .i_ready(rdy[3]), .i_clear_overrun(clr[3]),
        .o_data(data3), .o_valid(valid3), .o_parity_err(perr3), .o_frame_err(ferr3),
        .o_overrun(ovr3), .o_busy(busy3));

    // Free-running clock and an edge counter used for latency expectations.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        num_vectors++;
        if (act !== req) begin
            num_miscompares++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic pushExpect(input int inst, input exp_t e);
        case (inst)
            0: q0.push_back(e);
            1: q1.push_back(e);
            2: q2.push_back(e);
            default: q3.push_back(e);
        endcase
    endtask

    task automatic checkFrame(input int inst, input logic [8:0] d, input logic pe, input logic fe);
        exp_t e;
        logic got = 1'b0;
        case (inst)
            0: if (q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
            2: if (q2.size() > 0) begin e = q2.pop_front(); got = 1'b1; end
            default: if (q3.size() > 0) begin e = q3.pop_front(); got = 1'b1; end
        endcase
        if (!got) begin
            num_vectors++;
            num_miscompares++;
            $display("[TB] FAIL unexpected_frame inst=%0d actual data=%0h required none", inst, d);
        end else begin
            checkOutput($sformatf("data_i%0d", inst), 32'(d), 32'(e.data));
            checkOutput($sformatf("parity_err_i%0d", inst), 32'(pe), 32'(e.perr));
            checkOutput($sformatf("frame_err_i%0d", inst), 32'(fe), 32'(e.ferr));
            if (e.cyc >= 0) begin
                checkOutput($sformatf("latency_i%0d", inst), cyc, e.cyc);
            end
        end
    endtask

    // Drives start bit then nbits line bits (LSB first), CPB clocks each;
    // optionally pushes the expected frame, timed lat edges after edge 0.
    task automatic applyStimulus(input int inst, input logic [15:0] bits, input int nbits,
                                 input logic [8:0] d, input logic pe, input logic fe,
                                 input int lat, input logic push, output int c0);
        exp_t e;
        @(posedge clk);
        #1;
        c0 = cyc;
        if (push) begin
            e.data = d;
            e.perr = pe;
            e.ferr = fe;
            e.cyc  = (lat >= 0) ? (c0 + 1 + lat) : -1;
            pushExpect(inst, e);
        end
        rx[inst] = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int j = 0; j < nbits; j++) begin
            #1;
            rx[inst] = bits[j];
            repeat (CPB) @(posedge clk);
        end
        #1;
        rx[inst] = 1'b1;
    endtask

    // Monitor: pops and compares on every accepted frame; also tracks busy edges of the 8N1 unit.
    always @(negedge clk) begin
        if (valid0 === 1'b1 && rdy[0]) checkFrame(0, {1'b0, data0}, perr0, ferr0);
        if (valid1 === 1'b1 && rdy[1]) checkFrame(1, {1'b0, data1}, perr1, ferr1);
        if (valid2 === 1'b1 && rdy[2]) checkFrame(2, {1'b0, data2}, perr2, ferr2);
        if (valid3 === 1'b1 && rdy[3]) checkFrame(3, {4'b0, data3}, perr3, ferr3);
        if (busy0 === 1'b1 && !busy0_q) busy0_rise = cyc;
        if (busy0 === 1'b0 && busy0_q) busy0_fall = cyc;
        busy0_q = (busy0 === 1'b1);
    end

    // Hard time limit so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed stimulus sequence.
    initial begin
        int c0;
        int cd;
        rst = 4'hF;
        rx  = 4'hF;
        rdy = 4'h0;
        clr = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_valid", 32'(valid0), 0);
        checkOutput("reset_data", 32'(data0), 0);
        checkOutput("reset_flags", 32'({perr0, ferr0, ovr0, busy0}), 0);
        rst = 4'h0;
        rdy = 4'b0111;
        repeat (5) @(posedge clk);

        $display("[TB] 8N1 basic and back-to-back");
        applyStimulus(0, 16'({1'b1, 8'hA5}), 9, 9'h0A5, 1'b0, 1'b0, 154, 1'b1, c0);
        checkOutput("a5_busy_rise", busy0_rise, c0 + 3);
        checkOutput("a5_busy_fall", busy0_fall, c0 + 155);
        checkOutput("a5_valid_dropped", 32'(valid0), 0);
        applyStimulus(0, 16'({1'b1, 8'h5A}), 9, 9'h05A, 1'b0, 1'b0, 154, 1'b1, c0);
        applyStimulus(0, 16'({1'b1, 8'hC3}), 9, 9'h0C3, 1'b0, 1'b0, 154, 1'b1, c0);

        $display("[TB] 8N1 frame error");
        applyStimulus(0, 16'({1'b0, 8'h3C}), 9, 9'h03C, 1'b0, 1'b1, 154, 1'b1, c0);
        repeat (20) @(posedge clk);

        $display("[TB] glitch");
        #1;
        rx[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("glitch_busy_high", 32'(busy0), 1);
        rx[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("glitch_busy_low", 32'(busy0), 0);
        repeat (30) @(posedge clk);
        #1;
        checkOutput("glitch_no_valid", 32'(valid0), 0);

        $display("[TB] overrun");
        rdy[0] = 1'b0;
        applyStimulus(0, 16'({1'b1, 8'h11}), 9, 9'h011, 1'b0, 1'b0, -1, 1'b1, c0);
        checkOutput("ovr_first_valid", 32'(valid0), 1);
        checkOutput("ovr_first_flag", 32'(ovr0), 0);
        applyStimulus(0, 16'({1'b1, 8'h22}), 9, 9'h022, 1'b0, 1'b0, -1, 1'b0, c0);
        checkOutput("ovr_set", 32'(ovr0), 1);
        checkOutput("ovr_data_held", 32'(data0), 32'h11);
        clr[0] = 1'b1;
        @(posedge clk);
        #1;
        clr[0] = 1'b0;
        checkOutput("ovr_cleared", 32'(ovr0), 0);
        checkOutput("ovr_still_valid", 32'(valid0), 1);
        rdy[0] = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("ovr_consumed", 32'(valid0), 0);

        $display("[TB] even parity");
        applyStimulus(1, 16'({1'b1, 1'b1, 8'h07}), 10, 9'h007, 1'b0, 1'b0, 170, 1'b1, c0);
        applyStimulus(1, 16'({1'b1, 1'b0, 8'h07}), 10, 9'h007, 1'b1, 1'b0, 170, 1'b1, c0);

        $display("[TB] two stop bits");
        applyStimulus(2, 16'({1'b1, 1'b1, 8'h5A}), 10, 9'h05A, 1'b0, 1'b0, 170, 1'b1, c0);
        applyStimulus(2, 16'({1'b0, 1'b1, 8'h3C}), 10, 9'h03C, 1'b0, 1'b1, 170, 1'b1, c0);
        repeat (20) @(posedge clk);

        $display("[TB] 5N1 reset mid-frame");
        applyStimulus(3, 16'({1'b1, 5'h0A}), 6, 9'h000, 1'b0, 1'b0, -1, 1'b0, c0);
        checkOutput("d_held_valid", 32'(valid3), 1);
        checkOutput("d_held_data", 32'(data3), 32'h0A);
        fork
            applyStimulus(3, 16'({1'b1, 5'h1A}), 6, 9'h000, 1'b0, 1'b0, -1, 1'b0, cd);
            begin
                @(posedge clk);
                repeat (72) @(posedge clk);
                #1;
                checkOutput("d_busy_before_reset", 32'(busy3), 1);
                rst[3] = 1'b1;
                @(posedge clk);
                #1;
                checkOutput("d_reset_outputs", 32'({data3, valid3, perr3, ferr3, ovr3, busy3}), 0);
                rst[3] = 1'b0;
            end
        join
        rdy[3] = 1'b1;
        repeat (5) @(posedge clk);
        applyStimulus(3, 16'({1'b1, 5'h15}), 6, 9'h015, 1'b0, 1'b0, 106, 1'b1, c0);

        repeat (20) @(posedge clk);
        checkOutput("q0_left", q0.size(), 0);
        checkOutput("q1_left", q1.size(), 0);
        checkOutput("q2_left", q2.size(), 0);
        checkOutput("q3_left", q3.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", num_vectors, num_miscompares);
        $finish;
    end

endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver: the next generation of the team's fixed 8N1 receiver. Oversamples an asynchronous serial line with a configurable bit period, recovers 5–9 data bits with optional parity and one or two stop bits, and presents each frame through a one-entry valid/ready holding register with per-frame error flags and a sticky overrun flag. Sits between the board RX pin and any byte consumer, such as a FIFO or command decoder.

## Interface
- CLKS_PER_BIT, 21812, clock cycles per serial bit; must be ≥ 4. HALF_BIT = CLKS_PER_BIT/2, integer floor.
- DATA_BITS, 8, data bits per frame, 5..9.
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
- STOP_BITS, 1, stop bits per frame, 1 or 2.

- clk  in  1  single clock; all state updates on its rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_rx  in  1  asynchronous serial line; idles high.
- i_ready  in  1  consumer accepts the held frame when i_ready and o_valid are both high.
- i_clear_overrun  in  1  clears o_overrun.
- o_data  out  DATA_BITS  received data; first bit on the wire goes to o_data[0].
- o_valid  out  1  holding register holds an unconsumed frame.
- o_parity_err  out  1  parity mismatch for the held frame; always 0 when PARITY=0.
- o_frame_err  out  1  a stop bit sampled low for the held frame.
- o_overrun  out  1  sticky: a completed frame was dropped because the holding register was full.
- o_busy  out  1  receiver state is not IDLE.

## Operation
- **Synchroniser**
  - i_rx passes through two flops (s1, s2); both reset to 1.
  - All FSM decisions use s2.
- **Counter**
  - Width $clog2(CLKS_PER_BIT+1).
  - In DATA, PARITY and STOP the counter runs 0..CLKS_PER_BIT-1.
  - The bit is sampled when the counter reaches CLKS_PER_BIT-1; the counter then returns to 0.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - IDLE: when s2=0, go to START with count=1.
  - START, s2=1 at any point: glitch; go to IDLE with count=0 and no output.
  - START, s2=0: count increments each cycle. When count==HALF_BIT, go to DATA with count=0 and bit index=0.
  - DATA: at each sample, shift s2 into bit[index] and increment index. After bit DATA_BITS-1, go to PARITY if PARITY≠0, otherwise to STOP.
  - PARITY: one sample. Error if the XOR of the data bits and the parity bit is 0 (odd mode) or 1 (even mode). Then go to STOP.
  - STOP: STOP_BITS samples. Any low sample sets the frame-error flag for this frame. After the last stop sample: frame complete; go to IDLE with count, index and shift register cleared.
- **Holding register**, updated on frame completion:
  - If o_valid=0, or o_valid=1 and i_ready=1 in the same cycle: load o_data, o_parity_err and o_frame_err, and hold o_valid=1.
  - If o_valid=1 and i_ready=0: drop the new frame, set o_overrun=1, and leave the held data untouched.
- **Consume:** o_valid=1 and i_ready=1 with no completion in that cycle: o_valid=0 next cycle. o_data and the flags may hold stale values while o_valid=0.
- Frames with errors are still delivered, with their flags set. A break (all zeros plus a frame error) is delivered as a normal frame.
- **Overrun clear:** i_clear_overrun=1 clears o_overrun. If an overrun occurs in the same cycle, the set wins.

## Timing
- **Reset** (i_reset=1 at an edge), regardless of state:
  - o_data=0, o_valid=0, o_parity_err=0, o_frame_err=0, o_overrun=0, o_busy=0.
  - FSM goes to IDLE; counter, index and shift register are 0; s1=s2=1.
  - Reset mid-frame discards the partial frame. The next falling edge after release starts a clean frame.
- **Latency**
  - N = DATA_BITS + (PARITY≠0) + STOP_BITS.
  - Take the edge that first registers i_rx=0 into s1 as edge 0.
  - Bit k (k=1..N) is sampled at edge 2+HALF_BIT+k·CLKS_PER_BIT.
  - o_valid (with data and flags) is registered at edge 2+HALF_BIT+N·CLKS_PER_BIT, the same edge as the last stop sample.
- **o_busy:** 1 from edge 2 until the completion edge.
- **Back-to-back frames:** the FSM is back in IDLE mid-stop-bit, so a start bit immediately following the stop bit is detected with no dead time.
- **Handshake:** a consumer holding i_ready=1 permanently never sees an overrun, even at back-to-back rate.

## Test plan
Benches use CLKS_PER_BIT=16 (HALF_BIT=8) unless noted.
- **8N1 basic:** send 0xA5, line ideal. Expect o_valid=1 at edge 154 (=2+8+9·16); o_data=0xA5; both error flags 0; o_busy=1 over edges 2..153. With i_ready=1, o_valid=0 next cycle.
- **Parity, PARITY=2 (even):**
  - Send 0x07 with parity bit 1: o_parity_err=0.
  - Resend with parity bit 0: o_parity_err=1, o_data=0x07.
  - Expect o_valid for the first frame at edge 170.
- **Frame error:** send 0x3C with the stop bit driven low. Expect o_data=0x3C and o_frame_err=1. Repeat with STOP_BITS=2 and only the second stop bit low: o_frame_err=1.
- **Overrun:** with i_ready=0, send 0x11 then 0x22. Expect o_data to stay 0x11 and o_overrun=1 at the second completion. Then pulse i_clear_overrun: o_overrun=0. Assert i_ready: o_valid=0.
- **Glitch:** drive i_rx low for 4 cycles, then high. Expect a return to IDLE, o_busy to fall within 3 cycles of the line going high, and no o_valid.
- **Reset mid-frame, plus DATA_BITS=5:** assert i_reset during bit 3 of a frame. All outputs 0 the next cycle. The next frame, 0x15, is received correctly with o_data=5'h15.
